sync_fifo_pf: RTL and testbench

Parametrised single-clock FIFO, successor to `sync_fifo`. It adds:
- non-power-of-two depth;
- a selectable read mode (standard registered read or first-word-fall-through);
- a live fill count;
- run-time programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags.

It sits between a producer and a consumer in the same clock domain as the general buffering primitive.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_mem.sv | 32 +++
 rtl/sync_fifo_pf.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_pf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo family.
//   fifo_mode_e : read-mode selector (registered read or first-word-fall-through)
//   next_ptr    : pointer increment that wraps at an arbitrary depth
package sync_fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_pf: DEPTH x DW, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module sync_fifo_mem #(
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_pf.sv
// Single-clock FIFO with arbitrary depth, selectable read mode, live fill count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
//   clk, rst_n            : clock and synchronous active-low reset
//   wenable, wdata        : write request and data
//   renable, rdata        : read request (pop) and data
//   full, empty           : count == DEPTH, count == 0
//   almost_full/_empty    : count >= af_thresh, count <= ae_thresh
//   af_thresh, ae_thresh  : quasi-static thresholds
//   count                 : registered fill level, 0..DEPTH
//   clr_err               : clears overflow/underflow (wins over a same-cycle set)
//   overflow, underflow   : sticky write-while-full / read-while-empty
module sync_fifo_pf
    import sync_fifo_pkg::*;
#(
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 128,
    parameter fifo_mode_e  MODE  = FIFO_STD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wenable,
    input  logic [DW-1:0] wdata,
    output logic          full,
    output logic          almost_full,
    input  logic          renable,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          almost_empty,
    input  logic [AW:0]   af_thresh,
    input  logic [AW:0]   ae_thresh,
    output logic [AW:0]   count,
    input  logic          clr_err,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc, mem_we;
    logic [DW-1:0] mem_rdata;

    // Flags decode the registered count only; no request feeds through.
    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read while full does not free a slot for the same-cycle write.
    assign wr_acc = wenable && !full;
    assign rd_acc = renable && !empty;
    assign mem_we = wr_acc && rst_n;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wptr_d = AW'(next_ptr(32'(wptr_q), DEPTH));
        end
        if (rd_acc) begin
            rptr_d = AW'(next_ptr(32'(rptr_q), DEPTH));
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wenable && full) begin
                overflow_d = 1'b1;
            end
            if (renable && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is presented combinationally; zero while nothing is stored.
        assign rdata = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic [DW-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_acc) begin
                rdata_d = mem_rdata;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_pf.sv
// Self-checking bench for sync_fifo_pf: one STD and one FWFT instance share stimulus.
// A queue-based reference model tracks contents and error flags; STD read data is
// checked by a separate monitor that pops expected words from a scoreboard queue.
module tb_sync_fifo_pf;
    import sync_fifo_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wenable = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          renable = 1'b0;
    logic [AW:0]   af_thresh = 4'd5;
    logic [AW:0]   ae_thresh = 4'd1;
    logic          clr_err = 1'b0;

    logic          full_s, af_s, empty_s, ae_s, ovf_s, unf_s;
    logic [DW-1:0] rdata_s;
    logic [AW:0]   count_s;
    logic          full_f, af_f, empty_f, ae_f, ovf_f, unf_f;
    logic [DW-1:0] rdata_f;
    logic [AW:0]   count_f;

    always #5 clk = ~clk;

    sync_fifo_pf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MODE(FIFO_STD)) u_dut_std (
        .clk          (clk),
        .rst_n        (rst_n),
        .wenable      (wenable),
        .wdata        (wdata),
        .full         (full_s),
        .almost_full  (af_s),
        .renable      (renable),
        .rdata        (rdata_s),
        .empty        (empty_s),
        .almost_empty (ae_s),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count_s),
        .clr_err      (clr_err),
        .overflow     (ovf_s),
        .underflow    (unf_s)
    );

    sync_fifo_pf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_dut_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .wenable      (wenable),
        .wdata        (wdata),
        .full         (full_f),
        .almost_full  (af_f),
        .renable      (renable),
        .rdata        (rdata_f),
        .empty        (empty_f),
        .almost_empty (ae_f),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count_f),
        .clr_err      (clr_err),
        .overflow     (ovf_f),
        .underflow    (unf_f)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hold_m = '0;
    bit            ovf_m = 1'b0;
    bit            unf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: an accepted STD read must show the popped word after the edge.
    bit fire_s = 1'b0;
    always @(posedge clk) fire_s <= rst_n && renable && !empty_s;

    always @(negedge clk) begin
        if (fire_s) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_read: got 0x%0h expected no read", rdata_s);
            end else begin
                check("sb_rdata_std", rdata_s, exp_q.pop_front());
            end
        end
    end

    task automatic check_all();
        int cnt;
        logic [31:0] head;
        cnt  = model_q.size();
        head = (cnt == 0) ? 32'd0 : model_q[0];
        check("count_std", 32'(count_s), 32'(cnt));
        check("count_fwft", 32'(count_f), 32'(cnt));
        check("full_std", 32'(full_s), 32'(cnt == DEPTH));
        check("full_fwft", 32'(full_f), 32'(cnt == DEPTH));
        check("empty_std", 32'(empty_s), 32'(cnt == 0));
        check("empty_fwft", 32'(empty_f), 32'(cnt == 0));
        check("afull_std", 32'(af_s), 32'(cnt >= int'(af_thresh)));
        check("afull_fwft", 32'(af_f), 32'(cnt >= int'(af_thresh)));
        check("aempty_std", 32'(ae_s), 32'(cnt <= int'(ae_thresh)));
        check("aempty_fwft", 32'(ae_f), 32'(cnt <= int'(ae_thresh)));
        check("ovf_std", 32'(ovf_s), 32'(ovf_m));
        check("ovf_fwft", 32'(ovf_f), 32'(ovf_m));
        check("unf_std", 32'(unf_s), 32'(unf_m));
        check("unf_fwft", 32'(unf_f), 32'(unf_m));
        check("rdata_hold_std", rdata_s, hold_m);
        check("rdata_fwft", rdata_f, head);
    endtask

    // One clock: drive requests, let the edge happen, update the model, check state.
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr,
                        input bit rst);
        bit full_m, empty_m;
        wenable = we;
        wdata   = wd;
        renable = re;
        clr_err = clr;
        rst_n   = !rst;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            ovf_m  = 1'b0;
            unf_m  = 1'b0;
            hold_m = '0;
        end else begin
            full_m  = (model_q.size() == DEPTH);
            empty_m = (model_q.size() == 0);
            if (re && !empty_m) begin
                hold_m = model_q.pop_front();
                exp_q.push_back(hold_m);
            end
            if (we && !full_m) model_q.push_back(wd);
            if (clr) begin
                ovf_m = 1'b0;
                unf_m = 1'b0;
            end else begin
                if (we && full_m) ovf_m = 1'b1;
                if (re && empty_m) unf_m = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);

        // Fill and overflow
        for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
        step(1, 32'h200, 0, 0, 0);
        step(1, 32'h201, 0, 0, 0);

        // Drain and underflow; rdata must hold 0x105 across the underflow
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        // Wrap-around at half full
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 32'h400 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);

        // FWFT single word
        step(1, 32'hABCD, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 1, 0, 0);

        // Full with simultaneous read and write, then clear
        for (int i = 0; i < 6; i++) step(1, 32'h500 + 32'(i), 0, 0, 0);
        step(1, 32'h5FF, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        // clr_err wins over a same-cycle overflow
        step(1, 32'h600, 0, 0, 0);
        step(1, 32'h601, 0, 1, 0);

        // Reset mid-stream at count 4
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        step(1, 32'h777, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);

        // Threshold boundaries: 0 forces almost_full, above DEPTH disables it
        af_thresh = 4'd0;
        ae_thresh = 4'd0;
        step(1, 32'h800, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        af_thresh = 4'd7;
        ae_thresh = 4'd6;
        for (int i = 0; i < 7; i++) step(1, 32'h900 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0);

        // Randomized traffic
        af_thresh = 4'd5;
        ae_thresh = 4'd1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                af_thresh = 4'($urandom_range(0, 7));
                ae_thresh = 4'($urandom_range(0, 7));
            end
            step(bit'($urandom_range(0, 99) < 55), $urandom, bit'($urandom_range(0, 99) < 50),
                 bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 99) == 0));
        end
        step(0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
